// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store front end.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

endpackage

// File: rtl/mem_access_unit_lane_extract_merge.sv
// Little-endian lane handling: extracts and extends a load value from a word
// and merges sub-word store data into a word.
module lane_extract_merge
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] new_data,
    output logic [31:0] load_value,
    output logic [31:0] merged
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    assign byte_sh   = {lane, 3'b000};
    assign half_sh   = {lane[1], 4'b0000};
    assign byte_val  = 8'(word >> byte_sh);
    assign half_val  = 16'(word >> half_sh);
    assign byte_mask = 32'h0000_00FF << byte_sh;
    assign half_mask = 32'h0000_FFFF << half_sh;

    // Reserved size behaves exactly like a word access.
    always_comb begin
        load_value = word;
        merged     = new_data;
        case (size)
            SZ_BYTE: begin
                load_value = unsigned_ld ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
                merged     = (word & ~byte_mask) | ((32'(new_data[7:0]) << byte_sh) & byte_mask);
            end
            SZ_HALF: begin
                load_value = unsigned_ld ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
                merged     = (word & ~half_mask) | ((32'(new_data[15:0]) << half_sh) & half_mask);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end: turns byte/half/word requests into aligned
// word accesses, with read-modify-write for sub-word stores.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              access_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    state_e            state;
    state_e            state_next;
    logic              accept;
    logic              req_err;
    logic              req_sub;
    logic              cap_sub;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [1:0]        cap_size;
    logic              cap_unsigned;
    logic              cap_write;
    logic [31:0]       merged_q;
    logic [31:0]       ext_value;
    logic [31:0]       merge_value;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign req_sub   = (req_size == SZ_BYTE) || (req_size == SZ_HALF);
    assign cap_sub   = (cap_size == SZ_BYTE) || (cap_size == SZ_HALF);

    // Misalignment or an index past the end of memory rejects the request.
    always_comb begin
        req_err = (req_addr[ADDR_W-1:2] >= IDX_W'(MEM_WORDS));
        case (req_size)
            SZ_BYTE: ;
            SZ_HALF: if (req_addr[0]) req_err = 1'b1;
            default: if (req_addr[1:0] != 2'b00) req_err = 1'b1;
        endcase
    end

    lane_extract_merge u_lane (
        .word        (mem_rdata),
        .lane        (cap_addr[1:0]),
        .size        (cap_size),
        .unsigned_ld (cap_unsigned),
        .new_data    (cap_wdata),
        .load_value  (ext_value),
        .merged      (merge_value)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !req_err) begin
                    if (!req_write || req_sub) state_next = RD;
                    else                       state_next = WR;
                end
            end
            RD:      state_next = cap_write ? WR : RESP;
            WR:      state_next = IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes decode straight from state so the access lands in-cycle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (!reset) begin
            case (state)
                RD: begin
                    mem_read = 1'b1;
                    mem_addr = 32'({cap_addr[ADDR_W-1:2], 2'b00});
                end
                WR: begin
                    mem_write = 1'b1;
                    mem_addr  = 32'({cap_addr[ADDR_W-1:2], 2'b00});
                    mem_wdata = cap_sub ? merged_q : cap_wdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_valid   <= 1'b0;
            load_data    <= 32'h0;
            access_err   <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= 32'h0;
            cap_size     <= SZ_BYTE;
            cap_unsigned <= 1'b0;
            cap_write    <= 1'b0;
            merged_q     <= 32'h0;
        end else begin
            load_valid <= (state == RESP);
            access_err <= accept && req_err;
            if (accept) begin
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
                cap_write    <= req_write;
            end
            if (state == RD) begin
                if (cap_write) merged_q  <= merge_value;
                else           load_data <= ext_value;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model attached.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic        access_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(64), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .access_err   (access_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write)   mem[mem_addr[7:2]] <= mem_wdata;
        else if (pre_we) mem[pre_idx]       <= pre_data;
    end

    task automatic set_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
    endtask

    task automatic clr_req();
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        @(negedge clk); pre_we = 1'b1; pre_idx = idx; pre_data = d;
        @(negedge clk); pre_we = 1'b0;
    endtask

    // Issues a load and reports edges from acceptance to load_valid (-1 on timeout).
    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                           output logic [31:0] data, output int lat);
        lat = -1; data = 32'h0;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        set_req(1'b0, sz, u, a, 32'h0);
        @(negedge clk); clr_req();
        for (int i = 0; i < 10; i++) begin
            if (load_valid) begin lat = i; data = load_data; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clr_req(); pre_we = 1'b0; pre_idx = 6'd0; pre_data = 32'h0;
        repeat (2) @(negedge clk);
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_low got %b exp 0", req_ready); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b exp 1", req_ready); end
        vectors++; if ({load_valid, access_err, mem_read, mem_write} !== 4'b0000) begin miscompares++; $display("FAIL rst_flags got %b exp 0000", {load_valid, access_err, mem_read, mem_write}); end
        vectors++; if ({load_data, mem_addr, mem_wdata} !== 96'h0) begin miscompares++; $display("FAIL rst_data got %h %h %h exp 0", load_data, mem_addr, mem_wdata); end
    endtask

    task automatic test_word();
        logic [31:0] d; int lat;
        @(negedge clk); set_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        @(negedge clk); clr_req();
        vectors++; if ({mem_write, mem_read} !== 2'b10) begin miscompares++; $display("FAIL sw_strobe got %b exp 10", {mem_write, mem_read}); end
        vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL sw_addr got %h exp 00000010", mem_addr); end
        vectors++; if (mem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_wdata got %h exp deadbeef", mem_wdata); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL sw_busy got %b exp 0", req_ready); end
        @(negedge clk);
        vectors++; if ({req_ready, mem_write} !== 2'b10) begin miscompares++; $display("FAIL sw_done got %b exp 10", {req_ready, mem_write}); end
        set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge clk); clr_req();
        vectors++; if ({mem_read, mem_write, req_ready} !== 3'b100) begin miscompares++; $display("FAIL lw_rd got %b exp 100", {mem_read, mem_write, req_ready}); end
        vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL lw_addr got %h exp 00000010", mem_addr); end
        @(negedge clk);
        vectors++; if ({mem_read, req_ready, load_valid} !== 3'b000) begin miscompares++; $display("FAIL lw_resp got %b exp 000", {mem_read, req_ready, load_valid}); end
        @(negedge clk);
        vectors++; if ({load_valid, req_ready} !== 2'b11) begin miscompares++; $display("FAIL lw_valid got %b exp 11", {load_valid, req_ready}); end
        vectors++; if (load_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_data got %h exp deadbeef", load_data); end
        @(negedge clk);
        vectors++; if (load_valid !== 1'b0) begin miscompares++; $display("FAIL lw_pulse got %b exp 0", load_valid); end
        preload(6'd63, 32'hCAFEF00D);
        do_load(32'hFC, 2'b10, 1'b0, d, lat);
        vectors++; if (lat !== 2 || d !== 32'hCAFEF00D) begin miscompares++; $display("FAIL lw_last got lat %0d data %h exp lat 2 data cafef00d", lat, d); end
    endtask

    task automatic test_byte();
        logic [31:0] d; int lat;
        preload(6'd8, 32'h11223344);
        @(negedge clk); set_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AA);
        @(negedge clk); clr_req();
        vectors++; if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 32'h20) begin miscompares++; $display("FAIL sb_rd got %b addr %h exp 10 addr 00000020", {mem_read, mem_write}, mem_addr); end
        @(negedge clk);
        vectors++; if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 32'h20) begin miscompares++; $display("FAIL sb_wr got %b addr %h exp 01 addr 00000020", {mem_read, mem_write}, mem_addr); end
        vectors++; if (mem_wdata !== 32'h11AA3344) begin miscompares++; $display("FAIL sb_merge got %h exp 11aa3344", mem_wdata); end
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL sb_done got %b exp 1", req_ready); end
        do_load(32'h22, 2'b00, 1'b0, d, lat);
        vectors++; if (lat !== 2 || d !== 32'hFFFFFFAA) begin miscompares++; $display("FAIL lb got lat %0d data %h exp lat 2 data ffffffaa", lat, d); end
        do_load(32'h22, 2'b00, 1'b1, d, lat);
        vectors++; if (lat !== 2 || d !== 32'h000000AA) begin miscompares++; $display("FAIL lbu got lat %0d data %h exp lat 2 data 000000aa", lat, d); end
        do_load(32'h23, 2'b00, 1'b0, d, lat);
        vectors++; if (d !== 32'h00000011) begin miscompares++; $display("FAIL lb_b3 got %h exp 00000011", d); end
        do_load(32'h20, 2'b01, 1'b0, d, lat);
        vectors++; if (d !== 32'h00003344) begin miscompares++; $display("FAIL lh_lo got %h exp 00003344", d); end
    endtask

    task automatic test_half();
        logic [31:0] d; int lat;
        preload(6'd9, 32'h0);
        @(negedge clk); set_req(1'b1, 2'b01, 1'b0, 32'h26, 32'hFFFF8001);
        @(negedge clk); clr_req();
        vectors++; if (mem_read !== 1'b1 || mem_addr !== 32'h24) begin miscompares++; $display("FAIL sh_rd got %b addr %h exp 1 addr 00000024", mem_read, mem_addr); end
        @(negedge clk);
        vectors++; if (mem_write !== 1'b1 || mem_wdata !== 32'h80010000) begin miscompares++; $display("FAIL sh_merge got %b %h exp 1 80010000", mem_write, mem_wdata); end
        do_load(32'h26, 2'b01, 1'b0, d, lat);
        vectors++; if (lat !== 2 || d !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh got lat %0d data %h exp lat 2 data ffff8001", lat, d); end
        do_load(32'h26, 2'b01, 1'b1, d, lat);
        vectors++; if (lat !== 2 || d !== 32'h00008001) begin miscompares++; $display("FAIL lhu got lat %0d data %h exp lat 2 data 00008001", lat, d); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        logic        wr    [3];
        addrs = '{32'h13, 32'h21, 32'h100};
        sizes = '{2'b10, 2'b01, 2'b10};
        wr    = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_req(wr[i], sizes[i], 1'b0, addrs[i], 32'h5A5A5A5A);
            @(negedge clk); clr_req();
            vectors++; if ({access_err, mem_read, mem_write, req_ready, load_valid} !== 5'b10010) begin miscompares++; $display("FAIL err%0d_pulse got %b exp 10010", i, {access_err, mem_read, mem_write, req_ready, load_valid}); end
            @(negedge clk);
            vectors++; if ({access_err, mem_read, mem_write, req_ready} !== 4'b0001) begin miscompares++; $display("FAIL err%0d_after got %b exp 0001", i, {access_err, mem_read, mem_write, req_ready}); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; int lat; logic seen;
        preload(6'd12, 32'h55667788);
        @(negedge clk); set_req(1'b1, 2'b00, 1'b0, 32'h31, 32'h00000099);
        @(negedge clk); clr_req();
        @(negedge clk);
        vectors++; if (mem_write !== 1'b1) begin miscompares++; $display("FAIL rmid_inwr got %b exp 1", mem_write); end
        reset = 1'b1; #1;
        vectors++; if ({mem_write, mem_read} !== 2'b00) begin miscompares++; $display("FAIL rmid_gate got %b exp 00", {mem_write, mem_read}); end
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (load_valid || mem_write || mem_read) seen = 1'b1; end
        vectors++; if (seen !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_idle got activity %b ready %b exp 0 1", seen, req_ready); end
        do_load(32'h30, 2'b10, 1'b0, d, lat);
        vectors++; if (d !== 32'h55667788) begin miscompares++; $display("FAIL rmid_mem got %h exp 55667788", d); end
    endtask

    task automatic test_back_to_back();
        int waits; int lat;
        @(negedge clk); set_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADF00D);
        @(posedge clk);
        @(negedge clk); set_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        waits = 0;
        while (!req_ready && waits < 10) begin waits++; @(negedge clk); end
        vectors++; if (waits !== 1) begin miscompares++; $display("FAIL b2b_wait got %0d exp 1", waits); end
        @(negedge clk); clr_req();
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            if (load_valid) begin lat = i; break; end
            @(negedge clk);
        end
        vectors++; if (lat !== 2 || load_data !== 32'h0BADF00D) begin miscompares++; $display("FAIL b2b_load got lat %0d data %h exp lat 2 data 0badf00d", lat, load_data); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end of the MEM stage. Sits directly upstream of the word-addressed data memory.
- Accepts byte, halfword and word load/store requests from the EX/MEM pipeline register.
- Converts each request into aligned 32-bit memory reads/writes. Sub-word stores use a read-modify-write sequence. Load results are sign- or zero-extended for the MEM/WB register.
- Stalls upstream through a ready handshake while a multi-cycle access is in progress.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the downstream memory; word index range 0..MEM_WORDS-1.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; request is consumed when req_valid && req_ready at a rising edge.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word).
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; byte in [7:0], half in [15:0].
- load_valid  out  1  one-cycle pulse; load_data valid.
- load_data  out  32  extended load result.
- access_err  out  1  one-cycle pulse for a misaligned or out-of-range request.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  32  word-aligned byte address, {addr[31:2],2'b00}.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset values: state=IDLE, load_valid=0, load_data=0, access_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. req_ready is 1 after reset.
- req_ready = (state==IDLE) && !reset.
- Acceptance in IDLE captures addr, wdata, size, unsigned and write into registers.
- Error check at acceptance:
  - half with addr[0]!=0, or word with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS.
  - On error: no memory access, state stays IDLE, access_err=1 in the next cycle only.
- Load path: IDLE -> RD -> RESP -> IDLE.
  - In RD: mem_read=1, mem_addr set; mem_rdata is registered at the end of RD.
  - In RESP: load_valid=1 and load_data holds the extracted value.
  - Accept at edge N gives load_valid high in cycle N+2 (after edge N+2). The next request is accepted at edge N+3.
- Word store: IDLE -> WR -> IDLE. In WR: mem_write=1, mem_wdata=captured wdata. Memory updates at the end of the WR cycle.
- Sub-word store: IDLE -> RD -> WR -> IDLE.
  - RD registers the old word.
  - WR drives the merged word: the target lane is replaced, other lanes are unchanged.
- Lane mapping is little-endian:
  - byte k = addr[1:0] occupies bits [8k+7:8k].
  - half h = addr[1] occupies bits [16h+15:16h].
- Extension: sign bit is bit 7 (byte) or bit 15 (half). Word loads pass through unchanged.
- mem_read and mem_write are never both 1. Outside RD/WR both are 0 and mem_addr/mem_wdata are 0.
- Memory outputs are combinational decodes of state and captured registers, gated by !reset.
- Reset mid-operation: mem_write and mem_read are 0 in the cycle reset is high. The next state is IDLE, the pending request is dropped, and no load_valid is produced.
- load_valid and access_err never assert in the same cycle.

Decomposition:
- Shared package (mem_pkg): size encodings SZ_BYTE/SZ_HALF/SZ_WORD and state encodings.
- One sub-module, lane_extract_merge, combinational:
  - Inputs: word, addr[1:0], size, unsigned, new data.
  - Outputs: the extended load value and the merged store word.
  - Used by both the RD capture and the WR path.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> WR cycle has mem_write=1, mem_addr=0x10. load_valid exactly 2 cycles after load acceptance with load_data=0xDEADBEEF. req_ready low for 1 and 2 cycles respectively.
- Memory word @0x20 = 0x11223344; store byte 0xAA @0x22 -> RD then WR with mem_wdata=0x11AA3344. Then lb @0x22 gives 0xFFFFFFAA; lbu gives 0x000000AA.
- Store half 0x8001 @0x26 onto 0 -> mem_wdata=0x80010000. lh @0x26 gives 0xFFFF8001; lhu gives 0x00008001.
- lw @0x13, lh @0x21, and sw @0x100 (index 64 >= MEM_WORDS) -> access_err pulses once each, mem_read=mem_write=0 throughout, req_ready stays 1.
- Reset asserted during the WR cycle of a byte store -> mem_write=0 that cycle, memory word unchanged, IDLE with req_ready=1 afterwards, no load_valid.
- Back-to-back requests with req_valid held high, sw then lw to the same address -> the second is accepted only when req_ready=1, and the load returns the newly stored value.
